seg7_reader: RTL
================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4, setting the number of consecutive identical samples (after the first) required before a capture.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 i_reset  input  1  reset, synchronous, active-high.
REQ-004 i_hex0..i_hex3  input  7 each  active-low segment buses, bit0=a .. bit6=g, digit 0 least significant.
REQ-005 i_ready  input  1  consumer accepts the presented value.
REQ-006 o_valid  output  1  captured value presented.
REQ-007 o_value  output  16  decoded nibbles, o_value[4k+3:4k] from i_hexk.
REQ-008 o_digit_err  output  4  bit k set when i_hexk held no legal glyph at capture.
REQ-009 o_err_count  output  8  number of captures with any o_digit_err bit set.

Function
REQ-010 Legal glyphs (hex, active-low) SHALL be 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-011 Each illegal pattern, including blank 7F, SHALL decode to nibble 0 and set its o_digit_err bit.
REQ-012 The 28-bit bundle {i_hex3..i_hex0} SHALL be sampled every edge into a history register.
REQ-013 A stability counter SHALL increment, saturating at STABLE_CYCLES, when the new sample equals the history register, and SHALL clear to 0 otherwise.
REQ-014 States: WAIT (counting), PRESENT (o_valid=1), WAIT_CHANGE (already reported).
REQ-015 WAIT -> PRESENT on the edge where the counter reaches STABLE_CYCLES; that edge SHALL load o_value and o_digit_err from the sample.
REQ-016 Latency: with a bundle held constant from before edge k, o_valid SHALL be high after edge k+STABLE_CYCLES.
REQ-017 In PRESENT, o_value and o_digit_err SHALL stay constant until handshake, regardless of input changes.
REQ-018 Handshake: a transfer occurs on an edge with o_valid=1 and i_ready=1; o_valid SHALL drop on that edge and the state SHALL become WAIT_CHANGE.
REQ-019 i_ready while o_valid=0 SHALL have no effect.
REQ-020 WAIT_CHANGE -> WAIT, counter cleared, on the first edge whose sample differs from the last captured bundle; the same bundle SHALL never be reported twice in a row.
REQ-021 A bundle that changes and then returns to the captured value before the new value becomes stable SHALL be reported again.
REQ-022 Input changes in PRESENT SHALL be tracked by the counter, and on exit WAIT_CHANGE SHALL compare against the captured bundle.
REQ-023 o_err_count SHALL increment by 1 on each capture edge with any illegal digit, and SHALL saturate at 255.
REQ-024 STABLE_CYCLES=0 SHALL capture on the first sampled edge after entering WAIT.

Reset
REQ-025 While i_reset=1 at an edge: state=WAIT, counter=0, history=7F on all four digits, o_valid=0, o_value=0, o_digit_err=0, o_err_count=0.
REQ-026 Reset SHALL override a pending handshake; a value presented when reset is asserted SHALL be discarded and not re-reported unless re-captured.

Verification
REQ-027 S=4, bundle "0","3","A","F" (40,30,08,0E) applied before edge 1 with i_ready=0 -> o_valid=1 after edge 5, o_value=F A 3 0 = 16'hFA30, o_digit_err=0.
REQ-028 The same capture then i_ready=1 for 1 cycle with the bundle held -> o_valid=0 after handshake, and stays 0 for 20+ cycles.
REQ-029 i_hex2 toggles between 24 and 30 every 2 cycles (glitch) -> no capture; it then holds 24 -> o_value[11:8]=2 after 5 stable edges.
REQ-030 i_hex1=7F (blank), others legal -> o_digit_err=4'b0010, o_value[7:4]=0, o_err_count=1; 300 such distinct captures -> o_err_count=255.
REQ-031 i_reset=1 for 1 cycle while o_valid=1 -> o_valid=0, o_value=0 next cycle; the held bundle is re-captured 5 edges after reset release.

Source files
------------

// File: rtl/seg7_reader.sv
// seg7_reader: samples four active-low seven-segment digit buses, waits for
// the bundle to stay unchanged for STABLE_CYCLES further edges, then decodes
// it and presents the value through a valid/ready handshake. A value is
// reported once. The bundle must change before it can be reported again.
module seg7_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [6:0]  i_hex0,
   input  logic [6:0]  i_hex1,
   input  logic [6:0]  i_hex2,
   input  logic [6:0]  i_hex3,
   input  logic        i_ready,
   output logic        o_valid,
   output logic [15:0] o_value,
   output logic [3:0]  o_digit_err,
   output logic [7:0]  o_err_count
);

   // Counter wide enough to hold STABLE_CYCLES (at least one bit for S=0)
   localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   localparam logic [27:0] BLANK_BUNDLE = {4{7'h7F}};

   localparam logic [1:0] ST_WAIT        = 2'd0;
   localparam logic [1:0] ST_PRESENT     = 2'd1;
   localparam logic [1:0] ST_WAIT_CHANGE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [27:0]      hist_q, hist_d;
   logic [27:0]      cap_q, cap_d;
   logic             valid_q, valid_d;
   logic [15:0]      value_q, value_d;
   logic [3:0]       derr_q, derr_d;
   logic [7:0]       errcnt_q, errcnt_d;

   logic [27:0]      sample;
   logic [CNT_W-1:0] cnt_tracked;
   logic [15:0]      dec_value;
   logic [3:0]       dec_err;

   // Returns {illegal, nibble}; anything outside the sixteen glyphs is
   // illegal and decodes to nibble 0.
   function automatic logic [4:0] decode_glyph(input logic [6:0] g);
      logic [4:0] r;
      case (g)
         7'h40:   r = 5'h00;
         7'h79:   r = 5'h01;
         7'h24:   r = 5'h02;
         7'h30:   r = 5'h03;
         7'h19:   r = 5'h04;
         7'h12:   r = 5'h05;
         7'h02:   r = 5'h06;
         7'h78:   r = 5'h07;
         7'h00:   r = 5'h08;
         7'h10:   r = 5'h09;
         7'h08:   r = 5'h0A;
         7'h03:   r = 5'h0B;
         7'h46:   r = 5'h0C;
         7'h21:   r = 5'h0D;
         7'h06:   r = 5'h0E;
         7'h0E:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

   // Decode all four digits of the current sample
   always_comb begin
      sample    = {i_hex3, i_hex2, i_hex1, i_hex0};
      dec_value = '0;
      dec_err   = '0;
      for (int k = 0; k < 4; k++) begin
         {dec_err[k], dec_value[4*k +: 4]} = decode_glyph(sample[7*k +: 7]);
      end
   end

   // Stability tracking: count consecutive repeats of the sample, saturating
   always_comb begin
      if (sample == hist_q) begin
         cnt_tracked = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
         cnt_tracked = '0;
      end
   end

   // Next-state logic for the capture / present / wait-for-change sequence
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_tracked;
      hist_d   = sample;
      cap_d    = cap_q;
      valid_d  = valid_q;
      value_d  = value_q;
      derr_d   = derr_q;
      errcnt_d = errcnt_q;
      case (state_q)
         ST_WAIT: begin
            if (cnt_tracked == CNT_MAX) begin
               state_d = ST_PRESENT;
               valid_d = 1'b1;
               value_d = dec_value;
               derr_d  = dec_err;
               cap_d   = sample;
               if ((|dec_err) && (errcnt_q != 8'hFF)) begin
                  errcnt_d = errcnt_q + 8'd1;
               end
            end
         end
         ST_PRESENT: begin
            // Outputs hold; the counter keeps following the inputs
            if (i_ready) begin
               state_d = ST_WAIT_CHANGE;
               valid_d = 1'b0;
            end
         end
         ST_WAIT_CHANGE: begin
            // Compare against what was reported, not against the history,
            // so a bundle that changed during PRESENT still leaves here.
            if (sample != cap_q) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_WAIT;
            valid_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_WAIT;
         cnt_q    <= '0;
         hist_q   <= BLANK_BUNDLE;
         cap_q    <= BLANK_BUNDLE;
         valid_q  <= 1'b0;
         value_q  <= '0;
         derr_q   <= '0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hist_q   <= hist_d;
         cap_q    <= cap_d;
         valid_q  <= valid_d;
         value_q  <= value_d;
         derr_q   <= derr_d;
         errcnt_q <= errcnt_d;
      end
   end

   assign o_valid     = valid_q;
   assign o_value     = value_q;
   assign o_digit_err = derr_q;
   assign o_err_count = errcnt_q;

endmodule
